// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts a byte out on device clock falls, and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, clk_d, data_s1, data_s2;
  logic          fe;
  logic [9:0]    frame, frame_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rel_seen, rel_seen_nxt;
  logic          done_nxt, error_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_d    <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      state    <= IDLE;
      frame    <= '0;
      idx      <= '0;
      cnt      <= '0;
      rel_seen <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_d    <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
      state    <= state_nxt;
      frame    <= frame_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      rel_seen <= rel_seen_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
    end
  end

  assign fe = clk_d & ~clk_s2;

  always_comb begin
    state_nxt    = state;
    frame_nxt    = frame;
    idx_nxt      = idx;
    cnt_nxt      = cnt + CW'(1);
    rel_seen_nxt = 1'b0;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (tx_valid) begin
          // frame[0] is the start bit, so index 0 drives the line low in REQ
          frame_nxt = {~^tx_data, tx_data, 1'b0};
          state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      REQ, SHIFT: begin
        if (fe) begin
          cnt_nxt = '0;
          if (idx == 4'd9) begin
            state_nxt = ACK;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = SHIFT;
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          error_nxt = 1'b1;
          state_nxt = RELEASE;
        end
      end
      ACK: begin
        if (fe) begin
          done_nxt  = ~data_s2;
          error_nxt = data_s2;
          state_nxt = RELEASE;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          error_nxt = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        cnt_nxt = '0;
        if (clk_s2 && data_s2) begin
          if (rel_seen) state_nxt = IDLE;
          else          rel_seen_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = ((state == REQ) || (state == SHIFT)) && !frame[idx];

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, error;
  logic       dev_clk, dev_data;

  int total = 0;
  int bad   = 0;

  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int err_cyc = 0, chg_cyc = 0;
  logic err_oe = 1'b0;
  logic data_oe_prev = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done) done_cnt = done_cnt + 1;
    if (error) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
      err_oe  = ps2_clk_oe | ps2_data_oe;
    end
    if (done && error) both_cnt = both_cnt + 1;
    if (!error && ps2_data_oe != data_oe_prev) chg_cyc = cyc;
    data_oe_prev = ps2_data_oe;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits for the request-to-send, then clocks n falls, recording data_oe before each.
  task automatic dev_run(input int n, input logic ack, output logic [10:0] seq);
    int w;
    seq = '0;
    w = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("req_seen", {31'd0, ps2_data_oe && !ps2_clk_oe}, 32'd1);
    for (int k = 0; k < n; k++) begin
      if (k == 10) dev_data = ack;
      repeat (HALF) @(negedge clk);
      seq[k]  = ps2_data_oe;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!tx_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk(name, {31'd0, tx_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        ack;
    logic [10:0] seq;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [10:0] seq;
    int d0, e0, hi;

    tbl[0] = '{8'hED, 1'b0, 11'b00000100101, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 11'b00111111111, 1'b1, 1'b0};
    tbl[2] = '{8'h01, 1'b0, 11'b01111111101, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 11'b00000000001, 1'b1, 1'b0};
    tbl[4] = '{8'h5A, 1'b0, 11'b00101001011, 1'b1, 1'b0};
    tbl[5] = '{8'hED, 1'b1, 11'b00000100101, 1'b0, 1'b1};

    reset = 1'b0; tx_valid = 1'b0; tx_data = '0; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("rst_pulses", {30'd0, done, error}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Inhibit length; tx_valid held high into busy with changed data must be ignored.
    tx_valid = 1'b1; tx_data = 8'h01;
    @(negedge clk);
    chk("accept_cycle_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    tx_data = 8'hFF;
    hi = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) tx_valid = 1'b0;
      if (ps2_clk_oe) hi++;
      else break;
    end
    chk("inhibit_len", hi, 32'd8);
    chk("req_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
    d0 = done_cnt; e0 = err_cnt;
    dev_run(11, 1'b0, seq);
    chk("inh_seq_01", {21'd0, seq}, {21'd0, tbl[2].seq});
    wait_ready("inh_ready");
    chk("inh_done", done_cnt - d0, 32'd1);

    // Reset in the middle of shifting
    d0 = done_cnt; e0 = err_cnt;
    send(8'h5A);
    dev_run(3, 1'b0, seq);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);

    foreach (tbl[i]) begin
      d0 = done_cnt; e0 = err_cnt;
      send(tbl[i].data);
      dev_run(11, tbl[i].ack, seq);
      chk($sformatf("seq_%0d", i), {21'd0, seq}, {21'd0, tbl[i].seq});
      wait_ready($sformatf("ready_%0d", i));
      chk($sformatf("done_%0d", i), done_cnt - d0, {31'd0, tbl[i].exp_done});
      chk($sformatf("err_%0d", i), err_cnt - e0, {31'd0, tbl[i].exp_err});
      if (tbl[i].exp_err) chk($sformatf("err_oe_%0d", i), {31'd0, err_oe}, 32'd0);
    end

    // Device stops after 4 falls: error 100 cycles after the data line last moved.
    d0 = done_cnt; e0 = err_cnt;
    send(8'h08);
    dev_run(4, 1'b0, seq);
    for (int w = 0; w < 300 && err_cnt == e0; w++) @(negedge clk);
    chk("to_err", err_cnt - e0, 32'd1);
    chk("to_delay", err_cyc - chg_cyc, 32'd100);
    chk("to_oe", {31'd0, err_oe}, 32'd0);
    chk("to_done", done_cnt - d0, 32'd0);
    wait_ready("to_ready");

    chk("never_both", both_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000: clk cycles PS/2 clock is held low before a request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum clk cycles allowed between device falling edges (20 ms at 50 MHz).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 tx_data  input  8  command byte to send to the keyboard (e.g. 0xED, LED set).
REQ-006 tx_valid  input  1  request; the byte transfers when tx_valid and tx_ready are both high on a clk edge.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 ps2_clk_in, ps2_data_in  input  1 each  raw PS/2 line levels, asynchronous.
REQ-009 ps2_clk_oe, ps2_data_oe  output  1 each  1 = drive the line low, 0 = release (open-drain).
REQ-010 busy  output  1  high in every state except IDLE; the keyboard receiver ignores the bus while it is high.
REQ-011 done  output  1  one-cycle pulse when the device acknowledges the byte.
REQ-012 error  output  1  one-cycle pulse on missing ACK or timeout.

Function
REQ-013 Both PS/2 inputs pass through 2-flop synchronizers; a falling edge (fe) is sync clk 1 -> 0 between consecutive cycles.
REQ-014 States: IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE.
REQ-015 IDLE: all oe = 0. On accept, latch tx_data, compute odd parity (parity = ~^tx_data), go to INHIBIT.
REQ-016 INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, starting the cycle after accept; then go to REQ.
REQ-017 REQ: ps2_clk_oe = 0 and ps2_data_oe = 1 (start bit). The timeout counter clears on entry.
REQ-018 REQ/SHIFT: each fe advances a 4-bit index and sets the data line for the next bit, in the cycle after the fe is detected.
  - fe 1-8: data bits 0-7, LSB first; ps2_data_oe = ~bit.
  - fe 9: parity bit.
  - fe 10: stop bit, ps2_data_oe = 0; go to ACK.
REQ-019 ACK: on the next fe, sample synchronized data. 0 -> done pulse; 1 -> error pulse. Either way go to RELEASE.
REQ-020 RELEASE: all oe = 0. Return to IDLE when synced clk and data are both 1 for 2 consecutive cycles.
REQ-021 Timeout: in REQ, SHIFT and ACK, the counter clears on every fe. If it reaches TIMEOUT_CYCLES:
  - error pulse;
  - all oe = 0 in the same cycle the pulse is issued;
  - go to RELEASE.
REQ-022 tx_valid is ignored while busy; no queuing; tx_data is sampled only at accept.
REQ-023 done and error are never high in the same cycle; at most one of them pulses per accepted byte.
REQ-024 A fe while in INHIBIT or IDLE has no effect.

Reset
REQ-025 While reset = 0 at a clk edge: state IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, done = 0, error = 0, tx_ready = 1, counters and synchronizers cleared to idle-high.
REQ-026 Reset mid-transfer releases both lines at the next clk edge, with no done or error pulse.

Verification
REQ-027 INHIBIT_CYCLES = 8; send 0x01 -> ps2_clk_oe high for exactly 8 cycles, then ps2_data_oe = 1 with ps2_clk_oe = 0.
REQ-028 Device model clocks 11 falls for 0xED:
  - data_oe sequence (start..stop): 1,0,1,0,0,1,0,0,0,0,0, i.e. bits 1,0,1,1,0,1,1,1, parity 1, stop released;
  - model drives ACK 0 -> single done pulse, then RELEASE -> IDLE, tx_ready = 1.
REQ-029 Parity check:
  - 0x00 -> parity line released (bit 1);
  - 0x01 -> parity driven low (bit 0);
  - 0xFF -> parity bit 1.
REQ-030 Model leaves data high at the ACK fe -> error pulse, no done, lines released.
REQ-031 TIMEOUT_CYCLES = 100; model stops clocking after 4 falls -> error pulse exactly 100 cycles after the last fe, oe = 0.
REQ-032 reset = 0 during SHIFT bit 3 -> next edge: oe = 0, busy = 0, no pulse; a new send after reset completes normally.
